// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage with IF/ID register: PC sequencing, stall replay,
// redirect squash and sticky halt in front of a synchronous-read instruction memory.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_ADDR_W = 14,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   STALL,
    input  logic                   FLUSH,
    input  logic [31:0]            BRANCH_TARGET,
    input  logic                   HALT,
    output logic [IMEM_ADDR_W-1:0] IMEM_ADDR,
    input  logic [31:0]            IMEM_RDATA,
    output logic [31:0]            IF_ID_PC,
    output logic [31:0]            IF_ID_PC_PLUS4,
    output logic [31:0]            IF_ID_INSTR,
    output logic                   IF_ID_VALID
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_STALLED = 2'd1,
        S_HALTED  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_id_pc;
    logic        r_valid;
    logic        r_squash;
    logic [31:0] r_hold;
    logic        r_hold_sel;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_id_pc_nxt;
    logic        w_valid_nxt;
    logic        w_squash_nxt;
    logic [31:0] w_hold_nxt;
    logic        w_hold_sel_nxt;
    logic [31:0] w_instr;

    // Held word wins over memory data while stalled, since the memory keeps re-reading pc.
    always_comb begin
        if (!r_valid || r_squash) begin
            w_instr = NOP_INSTR;
        end else if (r_hold_sel) begin
            w_instr = r_hold;
        end else begin
            w_instr = IMEM_RDATA;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_id_pc_nxt    = r_id_pc;
        w_valid_nxt    = r_valid;
        w_squash_nxt   = r_squash;
        w_hold_nxt     = r_hold;
        w_hold_sel_nxt = r_hold_sel;
        case (r_state)
            S_RUN, S_STALLED: begin
                if (STALL) begin
                    w_state_nxt = S_STALLED;
                    if (r_state == S_RUN) begin
                        w_hold_nxt     = w_instr;
                        w_hold_sel_nxt = 1'b1;
                    end
                end else if (FLUSH) begin
                    w_state_nxt    = S_RUN;
                    w_pc_nxt       = BRANCH_TARGET & 32'hFFFF_FFFC;
                    w_id_pc_nxt    = r_pc;
                    w_valid_nxt    = 1'b1;
                    w_squash_nxt   = 1'b1;
                    w_hold_sel_nxt = 1'b0;
                end else if (HALT) begin
                    w_state_nxt    = S_HALTED;
                    w_valid_nxt    = 1'b0;
                    w_squash_nxt   = 1'b0;
                    w_hold_sel_nxt = 1'b0;
                end else begin
                    w_state_nxt    = S_RUN;
                    w_pc_nxt       = r_pc + 32'd4;
                    w_id_pc_nxt    = r_pc;
                    w_valid_nxt    = 1'b1;
                    w_squash_nxt   = 1'b0;
                    w_hold_sel_nxt = 1'b0;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_pc       <= RESET_PC;
            r_id_pc    <= RESET_PC;
            r_valid    <= 1'b0;
            r_squash   <= 1'b0;
            r_hold     <= NOP_INSTR;
            r_hold_sel <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_id_pc    <= w_id_pc_nxt;
            r_valid    <= w_valid_nxt;
            r_squash   <= w_squash_nxt;
            r_hold     <= w_hold_nxt;
            r_hold_sel <= w_hold_sel_nxt;
        end
    end

    assign IMEM_ADDR      = r_pc[IMEM_ADDR_W+1:2];
    assign IF_ID_PC       = r_id_pc;
    assign IF_ID_PC_PLUS4 = r_id_pc + 32'd4;
    assign IF_ID_INSTR    = w_instr;
    assign IF_ID_VALID    = r_valid & ~r_squash;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-scenario tasks push expected decode contents to a
// scoreboard queue as stimulus is driven and pop/compare after each clock edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic        vld;
        logic [13:0] addr;
        logic        chk_pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        STALL;
    logic        FLUSH;
    logic        HALT;
    logic [31:0] tgt;

    logic [13:0] addr_a, addr_b;
    logic [31:0] rdata_a, rdata_b;
    logic [31:0] pc_a, p4_a, ins_a;
    logic [31:0] pc_b, p4_b, ins_b;
    logic        vld_a, vld_b;

    int total = 0;
    int bad   = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    // Memory word i holds 32'h1000_0000 + i; one-cycle synchronous read.
    always @(posedge clk) begin
        rdata_a <= 32'h1000_0000 + {18'd0, addr_a};
        rdata_b <= 32'h1000_0000 + {18'd0, addr_b};
    end

    fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_W(14), .NOP_INSTR(NOP)) dut_a (
        .clk(clk), .rst_n(rst_n), .STALL(STALL), .FLUSH(FLUSH),
        .BRANCH_TARGET(tgt), .HALT(HALT), .IMEM_ADDR(addr_a), .IMEM_RDATA(rdata_a),
        .IF_ID_PC(pc_a), .IF_ID_PC_PLUS4(p4_a), .IF_ID_INSTR(ins_a), .IF_ID_VALID(vld_a)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .IMEM_ADDR_W(14), .NOP_INSTR(NOP)) dut_b (
        .clk(clk), .rst_n(rst_n), .STALL(STALL), .FLUSH(FLUSH),
        .BRANCH_TARGET(tgt), .HALT(HALT), .IMEM_ADDR(addr_b), .IMEM_RDATA(rdata_b),
        .IF_ID_PC(pc_b), .IF_ID_PC_PLUS4(p4_b), .IF_ID_INSTR(ins_b), .IF_ID_VALID(vld_b)
    );

    function automatic exp_t mk(input logic [31:0] pc, input logic vld,
                                input logic [13:0] addr, input logic chk);
        exp_t e;
        e.pc = pc; e.vld = vld; e.addr = addr; e.chk_pc = chk;
        return e;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'h1000_0000 + {18'd0, pc[15:2]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; STALL = 1'b0; FLUSH = 1'b0; HALT = 1'b0; tgt = 32'h0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (addr_a !== 14'd0) begin bad++; $display("FAIL reset_addr got=%h want=%h", addr_a, 14'd0); end
        total++; if (pc_a !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc_a, 32'h0); end
        total++; if (p4_a !== 32'h4) begin bad++; $display("FAIL reset_pc4 got=%h want=%h", p4_a, 32'h4); end
        total++; if (ins_a !== NOP) begin bad++; $display("FAIL reset_instr got=%h want=%h", ins_a, NOP); end
        total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", vld_a); end
    endtask

    task automatic test_sequential();
        exp_t e;
        logic [31:0] wi;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            q.push_back(mk(32'(4 * k), 1'b1, 14'(k + 1), 1'b1));
            step();
            e = q.pop_front();
            wi = e.vld ? word_at(e.pc) : NOP;
            total++; if (vld_a !== e.vld) begin bad++; $display("FAIL seq_valid k=%0d got=%b want=%b", k, vld_a, e.vld); end
            total++; if (ins_a !== wi) begin bad++; $display("FAIL seq_instr k=%0d got=%h want=%h", k, ins_a, wi); end
            total++; if (addr_a !== e.addr) begin bad++; $display("FAIL seq_addr k=%0d got=%h want=%h", k, addr_a, e.addr); end
            total++; if (pc_a !== e.pc) begin bad++; $display("FAIL seq_pc k=%0d got=%h want=%h", k, pc_a, e.pc); end
            total++; if (p4_a !== e.pc + 32'd4) begin bad++; $display("FAIL seq_pc4 k=%0d got=%h want=%h", k, p4_a, e.pc + 32'd4); end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        logic [31:0] wi;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            STALL = (k >= 3 && k <= 5);
            if (k < 3)      q.push_back(mk(32'(4 * k), 1'b1, 14'(k + 1), 1'b1));
            else if (k < 6) q.push_back(mk(32'd8, 1'b1, 14'd3, 1'b1));
            else            q.push_back(mk(32'(4 * (k - 3)), 1'b1, 14'(k - 2), 1'b1));
            step();
            e = q.pop_front();
            wi = e.vld ? word_at(e.pc) : NOP;
            total++; if (vld_a !== e.vld) begin bad++; $display("FAIL stall_valid k=%0d got=%b want=%b", k, vld_a, e.vld); end
            total++; if (ins_a !== wi) begin bad++; $display("FAIL stall_instr k=%0d got=%h want=%h", k, ins_a, wi); end
            total++; if (addr_a !== e.addr) begin bad++; $display("FAIL stall_addr k=%0d got=%h want=%h", k, addr_a, e.addr); end
            total++; if (pc_a !== e.pc) begin bad++; $display("FAIL stall_pc k=%0d got=%h want=%h", k, pc_a, e.pc); end
        end
        STALL = 1'b0;
    endtask

    task automatic test_flush();
        exp_t e;
        logic [31:0] wi;
        do_reset();
        tgt = 32'h40;
        for (int k = 0; k < 6; k++) begin
            FLUSH = (k == 3);
            case (k)
                3:       q.push_back(mk(32'd12, 1'b0, 14'h10, 1'b1));
                4:       q.push_back(mk(32'h40, 1'b1, 14'h11, 1'b1));
                5:       q.push_back(mk(32'h44, 1'b1, 14'h12, 1'b1));
                default: q.push_back(mk(32'(4 * k), 1'b1, 14'(k + 1), 1'b1));
            endcase
            step();
            e = q.pop_front();
            wi = e.vld ? word_at(e.pc) : NOP;
            total++; if (vld_a !== e.vld) begin bad++; $display("FAIL flush_valid k=%0d got=%b want=%b", k, vld_a, e.vld); end
            total++; if (ins_a !== wi) begin bad++; $display("FAIL flush_instr k=%0d got=%h want=%h", k, ins_a, wi); end
            total++; if (addr_a !== e.addr) begin bad++; $display("FAIL flush_addr k=%0d got=%h want=%h", k, addr_a, e.addr); end
            total++; if (pc_a !== e.pc) begin bad++; $display("FAIL flush_pc k=%0d got=%h want=%h", k, pc_a, e.pc); end
        end
        FLUSH = 1'b0;
    endtask

    task automatic test_stall_flush();
        exp_t e;
        logic [31:0] wi;
        do_reset();
        tgt = 32'h23;
        for (int k = 0; k < 7; k++) begin
            STALL = (k == 3);
            FLUSH = (k == 3 || k == 4);
            case (k)
                3:       q.push_back(mk(32'd8, 1'b1, 14'd3, 1'b1));
                4:       q.push_back(mk(32'd12, 1'b0, 14'd8, 1'b1));
                5:       q.push_back(mk(32'h20, 1'b1, 14'd9, 1'b1));
                6:       q.push_back(mk(32'h24, 1'b1, 14'd10, 1'b1));
                default: q.push_back(mk(32'(4 * k), 1'b1, 14'(k + 1), 1'b1));
            endcase
            step();
            e = q.pop_front();
            wi = e.vld ? word_at(e.pc) : NOP;
            total++; if (vld_a !== e.vld) begin bad++; $display("FAIL sf_valid k=%0d got=%b want=%b", k, vld_a, e.vld); end
            total++; if (ins_a !== wi) begin bad++; $display("FAIL sf_instr k=%0d got=%h want=%h", k, ins_a, wi); end
            total++; if (addr_a !== e.addr) begin bad++; $display("FAIL sf_addr k=%0d got=%h want=%h", k, addr_a, e.addr); end
            total++; if (pc_a !== e.pc) begin bad++; $display("FAIL sf_pc k=%0d got=%h want=%h", k, pc_a, e.pc); end
        end
        STALL = 1'b0;
        FLUSH = 1'b0;
    endtask

    task automatic test_halt();
        exp_t e;
        logic [31:0] wi;
        do_reset();
        tgt = 32'h80;
        for (int k = 0; k < 12; k++) begin
            HALT  = (k == 5);
            STALL = (k == 6 || k == 7);
            FLUSH = (k == 7 || k == 8);
            rst_n = (k != 10);
            if (k < 5)        q.push_back(mk(32'(4 * k), 1'b1, 14'(k + 1), 1'b1));
            else if (k < 10)  q.push_back(mk(32'd16, 1'b0, 14'd5, 1'b0));
            else if (k == 10) q.push_back(mk(32'd0, 1'b0, 14'd0, 1'b1));
            else              q.push_back(mk(32'd0, 1'b1, 14'd1, 1'b1));
            step();
            e = q.pop_front();
            wi = e.vld ? word_at(e.pc) : NOP;
            total++; if (vld_a !== e.vld) begin bad++; $display("FAIL halt_valid k=%0d got=%b want=%b", k, vld_a, e.vld); end
            total++; if (ins_a !== wi) begin bad++; $display("FAIL halt_instr k=%0d got=%h want=%h", k, ins_a, wi); end
            total++; if (addr_a !== e.addr) begin bad++; $display("FAIL halt_addr k=%0d got=%h want=%h", k, addr_a, e.addr); end
            if (e.chk_pc) begin
                total++; if (pc_a !== e.pc) begin bad++; $display("FAIL halt_pc k=%0d got=%h want=%h", k, pc_a, e.pc); end
            end
        end
        HALT = 1'b0; STALL = 1'b0; FLUSH = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [31:0] wi;
        do_reset();
        total++; if (pc_b !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_rst_pc got=%h want=%h", pc_b, 32'hFFFF_FFF8); end
        total++; if (addr_b !== 14'h3FFE) begin bad++; $display("FAIL wrap_rst_addr got=%h want=%h", addr_b, 14'h3FFE); end
        total++; if (vld_b !== 1'b0) begin bad++; $display("FAIL wrap_rst_valid got=%b want=0", vld_b); end
        q.push_back(mk(32'hFFFF_FFF8, 1'b1, 14'h3FFF, 1'b1));
        q.push_back(mk(32'hFFFF_FFFC, 1'b1, 14'h0000, 1'b1));
        q.push_back(mk(32'h0000_0000, 1'b1, 14'h0001, 1'b1));
        for (int k = 0; k < 3; k++) begin
            step();
            e = q.pop_front();
            wi = e.vld ? word_at(e.pc) : NOP;
            total++; if (vld_b !== e.vld) begin bad++; $display("FAIL wrap_valid k=%0d got=%b want=%b", k, vld_b, e.vld); end
            total++; if (ins_b !== wi) begin bad++; $display("FAIL wrap_instr k=%0d got=%h want=%h", k, ins_b, wi); end
            total++; if (addr_b !== e.addr) begin bad++; $display("FAIL wrap_addr k=%0d got=%h want=%h", k, addr_b, e.addr); end
            total++; if (pc_b !== e.pc) begin bad++; $display("FAIL wrap_pc k=%0d got=%h want=%h", k, pc_b, e.pc); end
            total++; if (p4_b !== e.pc + 32'd4) begin bad++; $display("FAIL wrap_pc4 k=%0d got=%h want=%h", k, p4_b, e.pc + 32'd4); end
        end
    endtask

    initial begin
        rst_n = 1'b0; STALL = 1'b0; FLUSH = 1'b0; HALT = 1'b0; tgt = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_stall_flush();
        test_halt();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
